// File: rtl/mdu_alu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_alu_sequencer
//   Multi-cycle unsigned MUL / MULHU / DIVU / REMU engine that borrows the
//   shared 32-bit combinational ALU. Each iterate cycle issues one add (MUL)
//   or one subtract (DIV) and folds the ALU result back into the shift
//   registers. Carry and borrow come from unsigned compares because the ALU
//   has no carry output.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op         request (taken only in IDLE); 00 MUL 01 MULHU 10 DIVU 11 REMU
//   operand_a/_b      rs1 / rs2
//   abort             cancels an operation in flight (no done)
//   busy              high while iterating; stalls the pipeline
//   done              one-cycle pulse when result becomes valid
//   result            final value, held until the next accepted start
//   alu_req           equals busy; steers decode mux to sequencer operands
//   alu_op_o/src/a/b  operands driven into the shared ALU
//   alu_result_i      ALU result fed back
// ---------------------------------------------------------------------------
module mdu_alu_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              alu_req,
   output logic [3:0]        alu_op_o,
   output logic              alu_src_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   input  logic [DATA_W-1:0] alu_result_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   logic [1:0]        state;
   logic              sel_hi;   // op[0]: MULHU / REMU pick the upper/remainder word
   logic [CNT_W-1:0]  cnt;
   // hi/rem and lo/quo share storage; mul and div never overlap.
   logic [DATA_W-1:0] acc_hi;
   logic [DATA_W-1:0] acc_lo;
   logic [DATA_W-1:0] b_q;      // multiplicand or divisor
   logic [DATA_W-1:0] result_q;

   logic [DATA_W-1:0] sh;
   logic              ob;
   logic              take;
   logic              carry;
   logic              last;
   logic [DATA_W-1:0] mul_hi, mul_lo, div_rem, div_quo;

   // Divide step: shift {rem,quo} left by one; ob is the bit shifted out of
   // rem, which makes the 33-bit partial remainder always >= divisor.
   assign sh    = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
   assign ob    = acc_hi[DATA_W-1];
   assign take  = ob | (sh >= b_q);
   // Adding a non-negative value wrapped iff the sum is below the addend.
   assign carry = (alu_result_i < acc_hi);
   assign last  = (cnt == CNT_W'(DATA_W-1));

   assign mul_hi  = {carry, alu_result_i[DATA_W-1:1]};
   assign mul_lo  = {alu_result_i[0], acc_lo[DATA_W-1:1]};
   assign div_rem = take ? alu_result_i : sh;
   assign div_quo = {acc_lo[DATA_W-2:0], take};

   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign alu_req   = busy;
   assign done      = (state == S_DONE);
   assign alu_src_o = 1'b0;
   assign result    = result_q;

   always_comb begin
      alu_op_o = ALU_ADD;
      alu_a_o  = '0;
      alu_b_o  = '0;
      case (state)
         S_MUL: begin
            alu_a_o = acc_hi;
            alu_b_o = acc_lo[0] ? b_q : '0;
         end
         S_DIV: begin
            alu_op_o = ALU_SUB;
            alu_a_o  = sh;
            alu_b_o  = b_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         sel_hi   <= 1'b0;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // abort beats a simultaneous start
               if (start && !abort) begin
                  sel_hi <= op[0];
                  cnt    <= '0;
                  acc_hi <= '0;
                  acc_lo <= operand_a;
                  b_q    <= operand_b;
                  if (!op[1])
                     state <= S_MUL;
                  else if (operand_b != '0)
                     state <= S_DIV;
                  else begin
                     // divide by zero: RISC-V defined results, no iteration
                     result_q <= op[0] ? operand_a : '1;
                     state    <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (abort)
                  state <= S_IDLE;
               else begin
                  acc_hi <= mul_hi;
                  acc_lo <= mul_lo;
                  cnt    <= cnt + CNT_W'(1);
                  if (last) begin
                     result_q <= sel_hi ? mul_hi : mul_lo;
                     state    <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (abort)
                  state <= S_IDLE;
               else begin
                  acc_hi <= div_rem;
                  acc_lo <= div_quo;
                  cnt    <= cnt + CNT_W'(1);
                  if (last) begin
                     result_q <= sel_hi ? div_rem : div_quo;
                     state    <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;  // S_DONE: start here is ignored
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Self-checking bench for mdu_alu_sequencer. The shared ALU is modelled as a
// plain add/sub; expected results come from 64-bit multiply and / % operators.
module tb_mdu_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [1:0]  op;
   logic [31:0] operand_a, operand_b;
   logic        busy, done, alu_req, alu_src_o;
   logic [31:0] result, alu_a_o, alu_b_o, alu_result_i;
   logic [3:0]  alu_op_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   assign alu_result_i = (alu_op_o == 4'b0001) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);

   mdu_alu_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
      .busy(busy), .done(done), .result(result), .alu_req(alu_req),
      .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .alu_a_o(alu_a_o),
      .alu_b_o(alu_b_o), .alu_result_i(alu_result_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one operation and follow it to done. pulse_at>0 raises a spurious
   // start (different op/operands) in that iterate cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int pulse_at);
      logic [31:0] exp;
      int lat, nbusy, exp_lat;
      bit side_ok;
      exp     = ref_result(o, a, b);
      exp_lat = (o[1] && b == 0) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(negedge clk);
      start = 1'b0; operand_a = $urandom; operand_b = $urandom;
      lat = 1; nbusy = 0; side_ok = 1'b1;
      while (!done && lat < 40) begin
         if (busy) begin
            nbusy++;
            if (alu_op_o !== (o[1] ? 4'b0001 : 4'b0000) || alu_req !== 1'b1 || alu_src_o !== 1'b0)
               side_ok = 1'b0;
         end else if (alu_req !== 1'b0 || alu_op_o !== 4'b0000 || alu_a_o !== 0 || alu_b_o !== 0)
            side_ok = 1'b0;
         if (lat == pulse_at) begin
            start = 1'b1; op = ~o; operand_a = $urandom; operand_b = $urandom;
         end else
            start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, "_done"},   32'(done), 32'd1);
      check({tag, "_lat"},    32'(lat), 32'(exp_lat));
      check({tag, "_nbusy"},  32'(nbusy), (exp_lat == 1) ? 32'd0 : 32'd32);
      check({tag, "_result"}, result, exp);
      check({tag, "_alu"},    32'(side_ok), 32'd1);
      @(negedge clk);
      check({tag, "_pulse"},  32'(done), 32'd0);
      check({tag, "_hold"},   result, exp);
      last_res = exp;
   endtask

   initial begin
      int ndone;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00;
      operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alureq", 32'(alu_req), 32'd0);
      check("rst_aluop",  32'(alu_op_o), 32'd0);
      check("rst_alua",   alu_a_o, 32'd0);
      check("rst_alub",   alu_b_o, 32'd0);
      rst = 1'b0;

      run_op("mul7x6",   2'b00, 32'd7, 32'd6, 0);
      run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("divu100",  2'b10, 32'd100, 32'd7, 0);
      run_op("remu100",  2'b11, 32'd100, 32'd7, 0);
      run_op("divu_ob",  2'b10, 32'h8000_0000, 32'd1, 0);
      run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0);
      run_op("remu5_9",  2'b11, 32'd5, 32'd9, 0);
      run_op("divu_z",   2'b10, 32'd1234, 32'd0, 0);
      run_op("remu_z",   2'b11, 32'd1234, 32'd0, 0);
      run_op("mul_mid",  2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5);

      // start during DONE is ignored
      @(negedge clk);
      start = 1'b1; op = 2'b10; operand_a = 32'd77; operand_b = 32'd0;
      @(negedge clk);
      check("dz_done", 32'(done), 32'd1);
      start = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("done_start_busy", 32'(busy), 32'd0);
      check("done_start_done", 32'(done), 32'd0);
      last_res = 32'hFFFF_FFFF;

      // abort and start together in IDLE: abort wins
      @(negedge clk);
      start = 1'b1; abort = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("idle_abort_busy", 32'(busy), 32'd0);

      // abort on the 10th DIVU iteration
      @(negedge clk);
      start = 1'b1; op = 2'b10; operand_a = 32'd1000; operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_pre_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      ndone = 0;
      repeat (40) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_nodone", 32'(ndone), 32'd0);
      check("abort_result", result, last_res);

      // reset during MUL_IT
      @(negedge clk);
      start = 1'b1; op = 2'b00; operand_a = 32'd11; operand_b = 32'd13;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy",   32'(busy), 32'd0);
      check("mrst_done",   32'(done), 32'd0);
      check("mrst_result", result, 32'd0);
      check("mrst_alu",    alu_a_o | alu_b_o | 32'(alu_op_o) | 32'(alu_req), 32'd0);
      run_op("mul3x5", 2'b00, 32'd3, 32'd5, 0);

      // randomized operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         run_op("rand", ro, ra, rb, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
